// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed, byte-strobed register array.
// Inserts WAIT_CYCLES ready-low ACCESS cycles before a one-cycle ready pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transfer in flight; a SETUP phase latches index and direction
// ST_WAIT | ACCESS phase, counting down wait cycles with ready low
// ST_RESP | ready high for one cycle; read data presented, write committed
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [3:0]            strb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NUM_LANES = 4;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic [IDX_W-1:0]      addr_idx;
  logic                  unused_addr;

  // Upper address bits are deliberately dropped: the array aliases modulo MEM_DEPTH.
  assign addr_idx    = addr[IDX_W-1:0];
  assign unused_addr = ^addr[ADDR_WIDTH-1:IDX_W];

  // Next-state logic: latch the transfer in SETUP, count waits, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE: begin
        if (sel && !enable) begin
          idx_d   = addr_idx;
          write_d = write;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!sel) begin
          state_d = ST_IDLE;
        end else if (enable) begin
          if (cnt_q == 4'd0) state_d = ST_RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are loaded on the edge entering RESP so they line up with that cycle.
  always_comb begin
    ready_d = (state_d == ST_RESP);
    rdata_d = '0;
    if ((state_d == ST_RESP) && !write_d) rdata_d = mem_q[idx_d];
  end

  // Write commit happens on the edge ending RESP, only while the master still holds ACCESS.
  always_comb begin
    mem_d = mem_q;
    if ((state_q == ST_RESP) && sel && enable && write_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (strb[i]) mem_d[idx_q][8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule
